// File: rtl/npc_trace_pkg.sv
// Shared types for the commit trace path: queue state and the commit record layout.
// Records are packed MSB-first as {pc, inst, is_break, seq}; seq is the LSB field so it can be dropped.
package npc_trace_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int SEQ_W  = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } trc_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              is_break;
    logic [SEQ_W-1:0]  seq;
  } cmt_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic DEPTH x WIDTH register FIFO; head visible 1 cycle after push, zero when empty.
// Backpressure: caller gates push on count < DEPTH; push/pop in the same cycle leave count unchanged.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Power-of-two depth: pointer overflow is the modulo wrap.
  assign push_ok = push && (count < DEPTH_C);
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Stale storage is never exposed: the head reads as zero while empty.
  assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/commit_trace_queue.sv
// Commit trace queue: buffers retired instructions for a host sink, 1-cycle push-to-head latency;
// cmt_ready drops when full or after an ebreak is accepted (drain, then halt). TRACE_SEQ_EN adds per-record trc_seq.
module commit_trace_queue import npc_trace_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmt_valid,
  output logic                       cmt_ready,
  input  logic [63:0]                cmt_pc,
  input  logic [31:0]                cmt_inst,
  input  logic                       cmt_is_break,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [63:0]                trc_pc,
  output logic [31:0]                trc_inst,
  output logic                       trc_is_break,
  output logic [31:0]                trc_seq,
  output logic                       halt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef TRACE_SEQ_EN
  localparam int REC_W = $bits(cmt_rec_t);
`else
  localparam int REC_W = $bits(cmt_rec_t) - SEQ_W;
`endif

  trc_state_t       state;
  trc_state_t       state_nxt;
  logic             live;
  logic             push;
  logic             pop;
  logic [REC_W-1:0] wr_dat;
  logic [REC_W-1:0] rd_dat;
  cmt_rec_t         rd_rec;

  // live holds cmt_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign cmt_ready = live && (state == RUN) && (count < DEPTH_C);
  assign push      = cmt_valid && cmt_ready;
  assign trc_valid = (count != '0);
  assign pop       = trc_valid && trc_ready;

`ifdef TRACE_SEQ_EN
  logic [SEQ_W-1:0] seq_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    seq_cnt <= '0;
    else if (push) seq_cnt <= seq_cnt + 1'b1;
  end

  assign wr_dat = {cmt_pc, cmt_inst, cmt_is_break, seq_cnt};
  assign rd_rec = rd_dat;
`else
  assign wr_dat = {cmt_pc, cmt_inst, cmt_is_break};
  assign rd_rec = {rd_dat, {SEQ_W{1'b0}}};
`endif

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (wr_dat),
    .pop      (pop),
    .head_dat (rd_dat),
    .count    (count)
  );

  assign trc_pc       = rd_rec.pc;
  assign trc_inst     = rd_rec.inst;
  assign trc_is_break = rd_rec.is_break;
  assign trc_seq      = rd_rec.seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Nothing is accepted after the ebreak, so its pop always empties the queue.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (push && cmt_is_break) state_nxt = DRAIN;
      DRAIN:   if (pop && trc_is_break)  state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  assign halt = (state == HALTED);

endmodule
